// File: rtl/dmem_line_backend.sv
// Line-granular data memory behind the L1 data cache: fixed-latency line read/write with a
// one-cycle ack and held read data. Define DMEM_STATS_EN to add saturating rd/wr counters.
module dmem_line_backend #(
    parameter int unsigned LATENCY     = 10,
    parameter int unsigned DEPTH_LINES = 512,
    parameter int unsigned LINE_W      = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_enable_i,
    input  logic              mem_write_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_ack_o
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       rd_cnt_o,
    output logic [15:0]       wr_cnt_o
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr;
    logic [IDX_W-1:0]  r_idx;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_rdata;
    logic [LINE_W-1:0] r_mem [DEPTH_LINES];

    logic [IDX_W-1:0]  w_idx;
    logic              w_done;
    logic              w_unused_addr;

    // Offset and upper bits are dropped, so addresses alias modulo the array size.
    assign w_idx         = mem_addr_i[IDX_W+4:5];
    assign w_unused_addr = ^{mem_addr_i[31:IDX_W+5], mem_addr_i[4:0]};
    assign w_done        = (r_state == ST_BUSY) && (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_enable_i) begin
                        r_wr    <= mem_write_i;
                        r_idx   <= w_idx;
                        r_wdata <= mem_data_i;
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_ACK;
                        if (!r_wr) begin
                            r_rdata <= r_mem[r_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // No reset on the array; reset forces IDLE, so an aborted write never commits.
    always_ff @(posedge clk_i) begin
        if (w_done && r_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign mem_data_o = r_rdata;
    assign mem_ack_o  = (r_state == ST_ACK);

`ifdef DMEM_STATS_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (r_state == ST_ACK) begin
            if (r_wr) begin
                if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
            end else begin
                if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
            end
        end
    end

    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;
`endif

endmodule

// File: tb/tb_dmem_line_backend.sv
// Directed bench for dmem_line_backend: a LATENCY=10 instance for core behaviour and a
// LATENCY=1 instance (sharing the request inputs) for short-latency and DMEM_STATS_EN checks.
module tb_dmem_line_backend;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         we;
    logic [31:0]  ad;
    logic [255:0] wd;
    logic [255:0] rdata1, rdata2;
    logic         ack1, ack2;
`ifdef DMEM_STATS_EN
    logic [15:0]  rd1, wr1, rd2, wr2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [255:0] D_PRE = {8{32'hA5A5_0003}};
    localparam logic [255:0] D_NEW = {8{32'h1234_5678}};
    localparam logic [255:0] D1    = {8{32'hC0DE_0400}};
    localparam logic [255:0] D2    = {8{32'hBEEF_0800}};
    localparam logic [255:0] D7    = {8{32'h7777_00E0}};
    localparam logic [255:0] D_BAD = {8{32'hDEAD_DEAD}};

    always #5 clk = ~clk;

    dmem_line_backend #(.LATENCY(10)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .mem_enable_i (en),
        .mem_write_i  (we),
        .mem_addr_i   (ad),
        .mem_data_i   (wd),
        .mem_data_o   (rdata1),
        .mem_ack_o    (ack1)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt_o     (rd1),
        .wr_cnt_o     (wr1)
`endif
    );

    dmem_line_backend #(.LATENCY(1)) dut_l1 (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .mem_enable_i (en),
        .mem_write_i  (we),
        .mem_addr_i   (ad),
        .mem_data_i   (wd),
        .mem_data_o   (rdata2),
        .mem_ack_o    (ack2)
`ifdef DMEM_STATS_EN
        ,
        .rd_cnt_o     (rd2),
        .wr_cnt_o     (wr2)
`endif
    );

    // Issue one request from IDLE; lat is the ack cycle counted from the sampling edge, -1 on timeout.
    task automatic xfer(input bit sel, input logic wr, input logic [31:0] addr,
                        input logic [255:0] data, output int lat);
        en = 1'b1; we = wr; ad = addr; wd = data; lat = -1;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if ((sel ? ack2 : ack1) === 1'b1) lat = k + 1;
        end
        en = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; we = 1'b0; ad = '0; wd = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ack1 !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", ack1); end
        n_cmp++; if (rdata1 !== '0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", rdata1); end
        n_cmp++; if (ack2 !== 1'b0) begin n_bad++; $display("FAIL reset_ack_l1 got=%b exp=0", ack2); end
`ifdef DMEM_STATS_EN
        n_cmp++; if (rd1 !== 16'd0 || wr1 !== 16'd0) begin
            n_bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", rd1, wr1);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_latency();
        int lat;
        xfer(1'b0, 1'b1, 32'h0000_4060, D_PRE, lat); // aliases line 3
        xfer(1'b0, 1'b0, 32'h0000_0060, '0, lat);
        n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL read_lat got=%0d exp=11", lat); end
        n_cmp++; if (rdata1 !== D_PRE) begin n_bad++; $display("FAIL read_data got=%h exp=%h", rdata1, D_PRE); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (rdata1 !== D_PRE || ack1 !== 1'b0) begin
                n_bad++; $display("FAIL read_hold cyc=%0d got=%h ack=%b exp=%h ack=0", i, rdata1, ack1, D_PRE);
            end
        end
    endtask

    task automatic test_write_then_read();
        int lat;
        xfer(1'b0, 1'b1, 32'h0000_0060, D_NEW, lat);
        n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL write_lat got=%0d exp=11", lat); end
        n_cmp++; if (rdata1 !== D_PRE) begin n_bad++; $display("FAIL write_keeps_data got=%h exp=%h", rdata1, D_PRE); end
        xfer(1'b0, 1'b0, 32'h0000_0060, '0, lat);
        n_cmp++; if (rdata1 !== D_NEW) begin n_bad++; $display("FAIL raw_data got=%h exp=%h", rdata1, D_NEW); end
    endtask

    task automatic test_back_to_back();
        int lat, k1, k2;
        xfer(1'b0, 1'b1, 32'h0000_0800, D2, lat);
        en = 1'b1; we = 1'b1; ad = 32'h0000_0400; wd = D1; k1 = -1; k2 = -1;
        for (int k = 0; k < 60 && k2 < 0; k++) begin
            @(posedge clk); #1;
            if (ack1 === 1'b1) begin
                if (k1 < 0) begin
                    k1 = k + 1; we = 1'b0; ad = 32'h0000_0800; wd = '0;
                end else begin
                    k2 = k + 1;
                end
            end
        end
        en = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (k1 !== 11) begin n_bad++; $display("FAIL b2b_first_ack got=%0d exp=11", k1); end
        n_cmp++; if (k2 - k1 !== 12) begin n_bad++; $display("FAIL b2b_gap got=%0d exp=12", k2 - k1); end
        n_cmp++; if (rdata1 !== D2) begin n_bad++; $display("FAIL b2b_refill got=%h exp=%h", rdata1, D2); end
        xfer(1'b0, 1'b0, 32'h0000_0400, '0, lat);
        n_cmp++; if (rdata1 !== D1) begin n_bad++; $display("FAIL b2b_wb_line got=%h exp=%h", rdata1, D1); end
    endtask

    task automatic test_busy_inputs();
        int lat, nack;
        en = 1'b1; we = 1'b0; ad = 32'h0000_0400; wd = '0; lat = -1; nack = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin en = 1'b0; we = 1'b1; ad = 32'h0000_0800; wd = D_BAD; end
            if (k > 2 && k < 9) begin ad = ad ^ 32'h0000_0020; wd = ~wd; end
            if (ack1 === 1'b1) begin nack++; if (lat < 0) lat = k + 1; end
        end
        we = 1'b0;
        n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL busy_lat got=%0d exp=11", lat); end
        n_cmp++; if (nack !== 1) begin n_bad++; $display("FAIL busy_ack_count got=%0d exp=1", nack); end
        n_cmp++; if (rdata1 !== D1) begin n_bad++; $display("FAIL busy_data got=%h exp=%h", rdata1, D1); end
        xfer(1'b0, 1'b0, 32'h0000_0800, '0, lat);
        n_cmp++; if (rdata1 !== D2) begin n_bad++; $display("FAIL busy_no_write got=%h exp=%h", rdata1, D2); end
    endtask

    task automatic test_reset_abort();
        int lat, nack;
        xfer(1'b0, 1'b1, 32'h0000_00E0, D7, lat);
        en = 1'b1; we = 1'b1; ad = 32'h0000_00E0; wd = D_BAD;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ack1 !== 1'b0 || rdata1 !== '0) begin
            n_bad++; $display("FAIL abort_in_reset got ack=%b data=%h exp ack=0 data=0", ack1, rdata1);
        end
        @(posedge clk); #1;
        n_cmp++; if (ack1 !== 1'b0 || rdata1 !== '0) begin
            n_bad++; $display("FAIL abort_held_reset got ack=%b data=%h exp ack=0 data=0", ack1, rdata1);
        end
        rst_n = 1'b1;
        nack = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (ack1 === 1'b1) nack++;
        end
        n_cmp++; if (nack !== 0) begin n_bad++; $display("FAIL abort_no_ack got=%0d exp=0", nack); end
        xfer(1'b0, 1'b0, 32'h0000_00E0, '0, lat);
        n_cmp++; if (rdata1 !== D7) begin n_bad++; $display("FAIL abort_line7 got=%h exp=%h", rdata1, D7); end
    endtask

    task automatic test_stats_lat1();
        int lat;
        logic [255:0] da, db;
        da = {8{32'h0101_0020}};
        db = {8{32'h0202_0040}};
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`ifdef DMEM_STATS_EN
        n_cmp++; if (rd2 !== 16'd0 || wr2 !== 16'd0) begin
            n_bad++; $display("FAIL stats_cleared got=%0d/%0d exp=0/0", rd2, wr2);
        end
`endif
        xfer(1'b1, 1'b1, 32'h0000_0020, da, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL l1_wr_lat got=%0d exp=2", lat); end
        xfer(1'b1, 1'b1, 32'h0000_0040, db, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL l1_wr2_lat got=%0d exp=2", lat); end
        xfer(1'b1, 1'b0, 32'h0000_0020, '0, lat);
        n_cmp++; if (lat !== 2 || rdata2 !== da) begin
            n_bad++; $display("FAIL l1_rd_a got lat=%0d data=%h exp lat=2 data=%h", lat, rdata2, da);
        end
        xfer(1'b1, 1'b0, 32'h0000_0040, '0, lat);
        n_cmp++; if (lat !== 2 || rdata2 !== db) begin
            n_bad++; $display("FAIL l1_rd_b got lat=%0d data=%h exp lat=2 data=%h", lat, rdata2, db);
        end
        xfer(1'b1, 1'b0, 32'h0000_0020, '0, lat);
        n_cmp++; if (lat !== 2 || rdata2 !== da) begin
            n_bad++; $display("FAIL l1_rd_a2 got lat=%0d data=%h exp lat=2 data=%h", lat, rdata2, da);
        end
`ifdef DMEM_STATS_EN
        n_cmp++; if (rd2 !== 16'd3) begin n_bad++; $display("FAIL stats_rd got=%0d exp=3", rd2); end
        n_cmp++; if (wr2 !== 16'd2) begin n_bad++; $display("FAIL stats_wr got=%0d exp=2", wr2); end
`endif
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_then_read();
        test_back_to_back();
        test_busy_inputs();
        test_reset_abort();
        test_stats_lat1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
